sram_match_scanner: RTL and testbench
=====================================

# sram_match_scanner

Shared back end for the 16 write-port SRAM matchers. Each cycle it presents every port's matcher with one candidate SRAM index and that SRAM's status: accessibility, free space, and the packet count for the port's destination. The scan order is collision-free per match mode. The block also owns the SRAM-to-write-port lock table: it grants or rejects locks when a matcher reports success, and clears locks when a port releases its SRAM.

## Interface
- PORT_NUM, 16, write ports served (fixed; index logic assumes 16)
- SRAM_NUM, 32, SRAMs scanned (fixed; 5-bit index)
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- match_mode  in  2  0 static, 1 semi-dynamic, 2/3 full-dynamic
- new_dest_port  in  16×4  per-port destination of the packet being matched
- match_suc  in  16  per-port one-cycle success pulse from the matcher
- matching_best_sram  in  16×5  per-port chosen SRAM, valid with match_suc
- wr_release  in  16  per-port pulse: packet written, drop lock
- sram_free_space  in  32×11  free half-words per SRAM
- sram_packet_amount  in  32×16×9  packets per SRAM per destination port; index [s*16+d]
- matching_sram  out  16×5  per-port candidate SRAM
- accessible  out  16  candidate is unlocked, or locked by this port
- free_space  out  16×11  candidate's free space
- packet_amount  out  16×9  candidate's count for new_dest_port[p]
- lock_ok  out  16  pulse: lock granted to port p
- lock_fail  out  16  pulse: lock rejected, port p must re-match

## Operation
- Scan tick: a 5-bit free-running counter, reset 0, +1 per cycle, wraps 31→0.
- Candidate index for port p, from the current tick t:
  - mode 0: {p[3:0], t[0]}, so each port owns SRAMs 2p and 2p+1.
  - mode 1: {p[3], (t[3:0] + {p[2:0],1'b0}) mod 16}, so each port scans its own half.
  - mode 2/3: (t + 2p) mod 32.
- These indices are pairwise distinct across ports in every cycle and every mode. The bench asserts this.
- Lock table: owned[31:0] and owner[31:0][3:0], both reset to 0.
- accessible[p] = ~owned[s] | (owner[s]==p), where s is port p's candidate.
- packet_amount[p] = sram_packet_amount[s*16+new_dest_port[p]].
- Lock request: match_suc[p] with matching_best_sram[p]=s. Requests are resolved in one cycle, in this order:
  1. All wr_release[p]: clear owned[s] for every s where owner[s]==p.
  2. Requests to an SRAM owned by another port (after step 1): lock_fail.
  3. Several ports requesting the same free SRAM: the lowest port index wins and gets lock_ok; the others get lock_fail.
  4. Request to an SRAM the requesting port already owns: lock_ok, table unchanged.
- One port holds at most one SRAM. A new lock_ok for port p first clears p's previous ownership.
- A match_mode change takes effect on the next index computation. Locks are kept.

## Timing
- Reset: all outputs are 0, tick is 0, and the lock table is cleared, including when reset is asserted mid-scan.
- The status outputs for port p (matching_sram, accessible, free_space, packet_amount) are always mutually consistent, i.e. they describe the same SRAM in the same cycle.
- With the pipe stage (see Configuration), the outputs in cycle n reflect the tick, lock table and sram_* inputs sampled at edge n. The lock table therefore lags one cycle.
- lock_ok / lock_fail: registered one-cycle pulse on the edge after match_suc. The table update happens on that same edge.
- Known one-cycle stale-accessible window: a matcher may select an SRAM just locked by another port. The lock_fail path covers this case.

## Configuration
- SCANNER_PIPE_EN:
  - Defined: status outputs are registered, giving 1-cycle latency from tick, table and inputs. This is the default in the build.
  - Undefined: status outputs are combinational from the current tick, table and sram_* inputs, with 0 latency.
  - In both cases lock_ok / lock_fail stay registered.

## Test plan
- Reset, mode 2, then 32 cycles: port 0 sees matching_sram 0..31 in order, port 5 sees 10..31,0..9, and no two ports share an index in any cycle.
- Mode 0: port 7 alternates 14,15. Mode 1: port 9 sees only 16..31, starting at 18 when tick=0.
- match_suc on ports 3 and 6, both with best SRAM 20, same cycle: next cycle lock_ok[3]=1 and lock_fail[6]=1. After that, accessible is 0 for every port except 3 whenever their candidate is 20.
- Port 3 holds SRAM 20; wr_release[3] and match_suc[6] (SRAM 20) in the same cycle: lock_ok[6]=1, owner[20]=6.
- Set sram_packet_amount[12*16+4]=77, new_dest_port[2]=4: in the cycle port 2's candidate is 12, packet_amount[2]=77 and free_space[2]=sram_free_space[12].
- Assert rst_n=0 for one cycle while locks are held: all outputs 0, then every candidate reads accessible=1.

Source files
------------

// File: rtl/sram_match_scanner.sv
// rtl/sram_match_scanner.sv - shared SRAM candidate scanner and SRAM-to-port lock table
// Purpose: every cycle hands each of the 16 write-port matchers one candidate SRAM
//          (collision-free across ports) with its status, and arbitrates lock requests.
// Ports:   clk, rst_n (synchronous, active-low)
//          in : match_mode[1:0], new_dest_port[16x4], match_suc[16], matching_best_sram[16x5],
//               wr_release[16], sram_free_space[32x11], sram_packet_amount[32x16x9]
//          out: matching_sram[16x5], accessible[16], free_space[16x11], packet_amount[16x9],
//               lock_ok[16], lock_fail[16]
//          Flattened vectors: entry i of width W sits at [i*W +: W];
//          sram_packet_amount entry (s,d) sits at [(s*16+d)*9 +: 9].
// Macro:   SCANNER_PIPE_EN - defined: status outputs registered (1-cycle latency);
//          undefined: status outputs combinational. lock_ok/lock_fail are always registered.
module sram_match_scanner (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    match_mode,
    input  logic [63:0]   new_dest_port,
    input  logic [15:0]   match_suc,
    input  logic [79:0]   matching_best_sram,
    input  logic [15:0]   wr_release,
    input  logic [351:0]  sram_free_space,
    input  logic [4607:0] sram_packet_amount,
    output logic [79:0]   matching_sram,
    output logic [15:0]   accessible,
    output logic [175:0]  free_space,
    output logic [143:0]  packet_amount,
    output logic [15:0]   lock_ok,
    output logic [15:0]   lock_fail
);
    localparam int PORT_NUM = 16;
    localparam int SRAM_NUM = 32;

    logic [4:0]          tick_q;
    logic [SRAM_NUM-1:0] owned_q;
    logic [SRAM_NUM-1:0] owned_rel;
    logic [SRAM_NUM-1:0] owned_d;
    logic [3:0]          owner_q [SRAM_NUM];
    logic [3:0]          owner_d [SRAM_NUM];
    logic [4:0]          best [PORT_NUM];
    logic [PORT_NUM-1:0] grant;
    logic [PORT_NUM-1:0] lock_ok_q;
    logic [PORT_NUM-1:0] lock_fail_q;

    logic [79:0]  sram_d;
    logic [15:0]  acc_d;
    logic [175:0] free_d;
    logic [143:0] pkt_d;

    // Each mode adds a port-dependent offset to the tick so no two ports ever land on the same SRAM.
    function automatic logic [4:0] cand_index(input logic [1:0] mode, input logic [4:0] t,
                                              input logic [3:0] p);
        logic [3:0] low;
        low = t[3:0] + {p[2:0], 1'b0};
        case (mode)
            2'd0:    cand_index = {p, t[0]};
            2'd1:    cand_index = {p[3], low};
            default: cand_index = t + {p, 1'b0};
        endcase
    endfunction

    always_comb begin
        for (int p = 0; p < PORT_NUM; p++) begin
            best[p] = matching_best_sram[p*5 +: 5];
        end
    end

    // Candidate status, all derived from one index so the four outputs always agree.
    always_comb begin
        sram_d = '0;
        acc_d  = '0;
        free_d = '0;
        pkt_d  = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            sram_d[p*5 +: 5]   = cand_index(match_mode, tick_q, 4'(p));
            acc_d[p]           = ~owned_q[sram_d[p*5 +: 5]] | (owner_q[sram_d[p*5 +: 5]] == 4'(p));
            free_d[p*11 +: 11] = sram_free_space[32'(sram_d[p*5 +: 5])*11 +: 11];
            pkt_d[p*9 +: 9]    = sram_packet_amount[(32'(sram_d[p*5 +: 5])*16
                                                     + 32'(new_dest_port[p*4 +: 4]))*9 +: 9];
        end
    end

    // Releases apply before any request is judged.
    always_comb begin
        owned_rel = owned_q;
        for (int s = 0; s < SRAM_NUM; s++) begin
            if (owned_q[s] && wr_release[owner_q[s]]) begin
                owned_rel[s] = 1'b0;
            end
        end
    end

    // Owned SRAM: only its owner is granted. Free SRAM: lowest requesting port wins.
    always_comb begin
        grant = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            if (match_suc[p]) begin
                if (owned_rel[best[p]]) begin
                    grant[p] = (owner_q[best[p]] == 4'(p));
                end else begin
                    grant[p] = 1'b1;
                    for (int q = 0; q < PORT_NUM; q++) begin
                        if (q < p && match_suc[q] && best[q] == best[p]) begin
                            grant[p] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // A port holds one SRAM: a grant for a different SRAM drops the port's old lock.
    always_comb begin
        owned_d = owned_rel;
        for (int s = 0; s < SRAM_NUM; s++) begin
            owner_d[s] = owner_q[s];
        end
        for (int s = 0; s < SRAM_NUM; s++) begin
            if (owned_rel[s] && grant[owner_q[s]] && best[owner_q[s]] != 5'(s)) begin
                owned_d[s] = 1'b0;
            end
        end
        for (int p = 0; p < PORT_NUM; p++) begin
            if (grant[p]) begin
                owned_d[best[p]] = 1'b1;
                owner_d[best[p]] = 4'(p);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_q      <= '0;
            owned_q     <= '0;
            lock_ok_q   <= '0;
            lock_fail_q <= '0;
            for (int s = 0; s < SRAM_NUM; s++) begin
                owner_q[s] <= '0;
            end
        end else begin
            tick_q      <= tick_q + 5'd1;
            owned_q     <= owned_d;
            lock_ok_q   <= grant;
            lock_fail_q <= match_suc & ~grant;
            for (int s = 0; s < SRAM_NUM; s++) begin
                owner_q[s] <= owner_d[s];
            end
        end
    end

    assign lock_ok   = lock_ok_q;
    assign lock_fail = lock_fail_q;

`ifdef SCANNER_PIPE_EN
    logic [79:0]  sram_q;
    logic [15:0]  acc_q;
    logic [175:0] free_q;
    logic [143:0] pkt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sram_q <= '0;
            acc_q  <= '0;
            free_q <= '0;
            pkt_q  <= '0;
        end else begin
            sram_q <= sram_d;
            acc_q  <= acc_d;
            free_q <= free_d;
            pkt_q  <= pkt_d;
        end
    end

    assign matching_sram = sram_q;
    assign accessible    = acc_q;
    assign free_space    = free_q;
    assign packet_amount = pkt_q;
`else
    // Outputs are forced to zero while reset is held, matching the registered variant.
    assign matching_sram = rst_n ? sram_d : '0;
    assign accessible    = rst_n ? acc_d  : '0;
    assign free_space    = rst_n ? free_d : '0;
    assign packet_amount = rst_n ? pkt_d  : '0;
`endif

endmodule

// File: tb/tb_sram_match_scanner.sv
// tb/tb_sram_match_scanner.sv - directed self-checking bench for sram_match_scanner
module tb_sram_match_scanner;
`ifdef SCANNER_PIPE_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    match_mode;
    logic [63:0]   new_dest_port;
    logic [15:0]   match_suc;
    logic [79:0]   matching_best_sram;
    logic [15:0]   wr_release;
    logic [351:0]  sram_free_space;
    logic [4607:0] sram_packet_amount;
    logic [79:0]   matching_sram;
    logic [15:0]   accessible;
    logic [175:0]  free_space;
    logic [143:0]  packet_amount;
    logic [15:0]   lock_ok;
    logic [15:0]   lock_fail;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;
    int own_of [32];
    int dest_of [16];

    always #5 clk = ~clk;

    sram_match_scanner dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .match_mode         (match_mode),
        .new_dest_port      (new_dest_port),
        .match_suc          (match_suc),
        .matching_best_sram (matching_best_sram),
        .wr_release         (wr_release),
        .sram_free_space    (sram_free_space),
        .sram_packet_amount (sram_packet_amount),
        .matching_sram      (matching_sram),
        .accessible         (accessible),
        .free_space         (free_space),
        .packet_amount      (packet_amount),
        .lock_ok            (lock_ok),
        .lock_fail          (lock_fail)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic int tick_now();
        return ((cyc - LAT) % 32 + 32) % 32;
    endfunction

    function automatic int exp_idx(input int mode, input int t, input int p);
        if (mode == 0) return 2 * p + (t % 2);
        if (mode == 1) return (p >= 8 ? 16 : 0) + (t + 2 * (p % 8)) % 16;
        return (t + 2 * p) % 32;
    endfunction

    function automatic int dut_idx(input int p);
        return int'(matching_sram[p*5 +: 5]);
    endfunction

    function automatic int exp_pkt(input int s, input int d);
        return (s == 12 && d == 4) ? 77 : s * 3 + d;
    endfunction

    task automatic check_status(input string tag);
        logic [79:0]  e_sram;
        logic [15:0]  e_acc;
        logic [175:0] e_free;
        logic [143:0] e_pkt;
        logic [31:0]  seen;
        logic         dup;
        int           s;
        e_sram = '0; e_acc = '0; e_free = '0; e_pkt = '0; seen = '0; dup = 1'b0;
        for (int p = 0; p < 16; p++) begin
            s = exp_idx(int'(match_mode), tick_now(), p);
            e_sram[p*5 +: 5]   = 5'(s);
            e_acc[p]           = (own_of[s] < 0) || (own_of[s] == p);
            e_free[p*11 +: 11] = 11'(100 + s);
            e_pkt[p*9 +: 9]    = 9'(exp_pkt(s, dest_of[p]));
            if (seen[dut_idx(p)]) dup = 1'b1;
            seen[dut_idx(p)] = 1'b1;
        end
        check({tag, "_sram"}, matching_sram, e_sram);
        check({tag, "_acc"}, accessible, e_acc);
        check({tag, "_free"}, free_space, e_free);
        check({tag, "_pkt"}, packet_amount, e_pkt);
        check({tag, "_distinct"}, dup, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_sram"}, matching_sram, 0);
        check({tag, "_acc"}, accessible, 0);
        check({tag, "_free"}, free_space, 0);
        check({tag, "_pkt"}, packet_amount, 0);
        check({tag, "_ok"}, lock_ok, 0);
        check({tag, "_fail"}, lock_fail, 0);
    endtask

    task automatic set_best(input int p, input int s);
        matching_best_sram[p*5 +: 5] = 5'(s);
    endtask

    initial begin
        rst_n = 1'b0;
        match_mode = 2'd0;
        new_dest_port = '0;
        match_suc = '0;
        matching_best_sram = '0;
        wr_release = '0;
        for (int s = 0; s < 32; s++) begin
            sram_free_space[s*11 +: 11] = 11'(100 + s);
            own_of[s] = -1;
            for (int d = 0; d < 16; d++) begin
                sram_packet_amount[(s*16+d)*9 +: 9] = 9'(s * 3 + d);
            end
        end
        sram_packet_amount[(12*16+4)*9 +: 9] = 9'd77;
        for (int p = 0; p < 16; p++) dest_of[p] = 0;

        // Reset state
        step();
        step();
        check_zero("reset");

        // Mode 2: full 32-cycle rotation
        match_mode = 2'd2;
        cyc = 0;
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            step();
            check_status("m2");
            check("m2_p0", dut_idx(0), tick_now());
            check("m2_p5", dut_idx(5), (tick_now() + 10) % 32);
        end

        // Mode 0: port 7 alternates 14/15
        match_mode = 2'd0;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            check_status("m0");
            check("m0_p7", dut_idx(7), 14 + tick_now() % 2);
        end

        // Mode 1: port 9 stays in the upper half, 18 at tick 0
        match_mode = 2'd1;
        step();
        for (int i = 0; i < 32; i++) begin
            step();
            check_status("m1");
            check("m1_p9", dut_idx(9), 16 + (tick_now() + 2) % 16);
        end

        // Ports 3 and 6 both request free SRAM 20
        match_mode = 2'd2;
        set_best(3, 20);
        set_best(6, 20);
        match_suc = 16'h0048;
        step();
        match_suc = '0;
        check("tie_ok", lock_ok, 16'h0008);
        check("tie_fail", lock_fail, 16'h0040);
        own_of[20] = 3;
        step();
        check("pulse_ok", lock_ok, 16'h0000);
        check("pulse_fail", lock_fail, 16'h0000);
        step();
        for (int i = 0; i < 32; i++) begin
            step();
            check_status("lock3");
        end

        // Release by 3 and request by 6 in the same cycle
        wr_release = 16'h0008;
        match_suc = 16'h0040;
        step();
        wr_release = '0;
        match_suc = '0;
        check("relreq_ok", lock_ok, 16'h0040);
        check("relreq_fail", lock_fail, 16'h0000);
        own_of[20] = 6;
        step();
        step();
        for (int i = 0; i < 32; i++) begin
            step();
            check_status("lock6");
        end

        // Port 6 moves to SRAM 21: old lock on 20 dropped
        set_best(6, 21);
        match_suc = 16'h0040;
        step();
        match_suc = '0;
        check("move_ok", lock_ok, 16'h0040);
        check("move_fail", lock_fail, 16'h0000);
        own_of[20] = -1;
        own_of[21] = 6;
        step();
        step();
        for (int i = 0; i < 32; i++) begin
            step();
            check_status("move");
        end

        // Port 6 re-requests its own SRAM while port 1 tries to take it
        set_best(1, 21);
        match_suc = 16'h0042;
        step();
        match_suc = '0;
        check("own_ok", lock_ok, 16'h0040);
        check("own_fail", lock_fail, 16'h0002);
        step();
        step();
        for (int i = 0; i < 8; i++) begin
            step();
            check_status("own");
        end

        // Packet amount lookup by destination
        dest_of[2] = 4;
        new_dest_port[8 +: 4] = 4'd4;
        step();
        for (int i = 0; i < 32; i++) begin
            step();
            check_status("pkt");
            if (exp_idx(2, tick_now(), 2) == 12) begin
                check("pkt_p2_77", packet_amount[18 +: 9], 9'd77);
                check("pkt_p2_free", free_space[22 +: 11], 11'd112);
            end
        end

        // Reset mid-scan with SRAM 21 locked
        rst_n = 1'b0;
        step();
        check_zero("midrst");
        for (int s = 0; s < 32; s++) own_of[s] = -1;
        cyc = 0;
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            step();
            check_status("postrst");
            check("postrst_acc", accessible, 16'hFFFF);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
